// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IDLE/FETCH/WAIT/ISSUE/HALT instruction fetch sequencer; FETCH_SEQ_PERF_EN adds cycle/retire counters.
`ifndef WIDTH
`define WIDTH 32
`endif

module fetch_sequencer (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              imem_req,
   output logic [`WIDTH-1:0] imem_addr,
   input  logic              imem_valid,
   input  logic [`WIDTH-1:0] imem_data,
   output logic [`WIDTH-1:0] inst,
   output logic              inst_valid,
   input  logic              exec_ready,
   input  logic              halted,
   input  logic              branch_taken,
   input  logic [`WIDTH-1:0] branch_target,
   output logic              running,
`ifdef FETCH_SEQ_PERF_EN
   output logic [`WIDTH-1:0] cycle_count,
   output logic [`WIDTH-1:0] retired_count,
`endif
   output logic [`WIDTH-1:0] pc
);
   typedef enum logic [2:0] {IDLE, FETCH, WAIT, ISSUE, HALT} state_t;
   state_t state, next_state;
   logic accept;
   always_comb begin
      accept     = (state == ISSUE) && exec_ready;
      imem_req   = state == FETCH;
      imem_addr  = imem_req ? pc : '0;
      inst_valid = state == ISSUE;
      running    = (state == FETCH) || (state == WAIT) || (state == ISSUE);
      next_state = (state == IDLE && start)     ? FETCH :
                   (state == FETCH)             ? WAIT  :
                   (state == WAIT && imem_valid) ? ISSUE :
                   accept                       ? (halted ? HALT : FETCH) :
                                                  state;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc    <= '0;
         inst  <= '0;
      end else begin
         state <= next_state;
         if (state == WAIT && imem_valid)
            inst <= imem_data;
         if (accept && !halted)
            pc <= branch_taken ? {branch_target[`WIDTH-1:2], 2'b00} : pc + `WIDTH'(4);
      end
   end
`ifdef FETCH_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_count   <= '0;
         retired_count <= '0;
      end else begin
         cycle_count   <= cycle_count + `WIDTH'(running && !(&cycle_count));
         retired_count <= retired_count + `WIDTH'(accept && !(&retired_count));
      end
   end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: table-driven fetch/issue runs with queue scoreboard plus reset and halt corner sequences.
`ifndef WIDTH
`define WIDTH 32
`endif

module tb_fetch_sequencer;
   logic              clk = 0, reset = 1, start = 0;
   logic              imem_req, imem_valid = 0, inst_valid, exec_ready = 0;
   logic              halted = 0, branch_taken = 0, running;
   logic [`WIDTH-1:0] imem_addr, imem_data = '0, inst, branch_target = '0, pc;
`ifdef FETCH_SEQ_PERF_EN
   logic [`WIDTH-1:0] cycle_count, retired_count;
`endif
   int total = 0, bad = 0;
   logic [31:0] addr_q[$], inst_q[$];

   fetch_sequencer dut (
      .clk(clk), .reset(reset), .start(start),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_valid(imem_valid), .imem_data(imem_data),
      .inst(inst), .inst_valid(inst_valid), .exec_ready(exec_ready),
      .halted(halted), .branch_taken(branch_taken), .branch_target(branch_target),
      .running(running),
`ifdef FETCH_SEQ_PERF_EN
      .cycle_count(cycle_count), .retired_count(retired_count),
`endif
      .pc(pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      logic [31:0] addr;
      logic [31:0] word;
      bit          br;
      logic [31:0] tgt;
      bit          hlt;
      int          stall;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic restart();
      reset = 1;
      @(negedge clk);
      reset = 0;
      start = 1;
      @(negedge clk);
      start = 0;
   endtask

   task automatic run_instr(input vec_t v);
      int n = 0;
      logic [31:0] e;
      addr_q.push_back(v.addr);
      while (!imem_req && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("req_seen", 32'(imem_req), 1);
      e = addr_q.pop_front();
      chk("imem_addr", imem_addr, e);
      chk("pc_fetch", pc, e);
      @(negedge clk);
      chk("req_one_cycle", 32'(imem_req), 0);
      chk("valid_in_wait", 32'(inst_valid), 0);
      imem_valid = 1;
      imem_data  = v.word;
      inst_q.push_back(v.word);
      @(negedge clk);
      imem_valid = 0;
      e = inst_q.pop_front();
      chk("inst_valid", 32'(inst_valid), 1);
      chk("inst", inst, e);
      halted        = v.hlt;
      branch_taken  = v.br;
      branch_target = v.tgt;
      for (int s = 0; s < v.stall; s++) begin
         exec_ready = 0;
         if (s == 0) begin
            imem_valid = 1;
            imem_data  = ~v.word;
         end
         @(negedge clk);
         imem_valid = 0;
         chk("stall_valid", 32'(inst_valid), 1);
         chk("stall_inst", inst, e);
         chk("stall_pc", pc, v.addr);
      end
      exec_ready = 1;
      @(negedge clk);
      exec_ready   = 0;
      halted       = 0;
      branch_taken = 0;
   endtask

   initial begin
      tbl[0] = '{1, 32'h0,        32'h1111_0001, 0, 32'h0,         0, 0};
      tbl[1] = '{0, 32'h4,        32'h2222_0002, 0, 32'h0,         0, 0};
      tbl[2] = '{0, 32'h8,        32'h3333_0003, 0, 32'h0,         0, 0};
      tbl[3] = '{0, 32'hC,        32'hDEAD_0004, 0, 32'h0,         1, 0};
      tbl[4] = '{1, 32'h0,        32'hA000_0001, 0, 32'h0,         0, 0};
      tbl[5] = '{0, 32'h4,        32'hA000_0002, 1, 32'h43,        0, 0};
      tbl[6] = '{0, 32'h40,       32'hA000_0003, 1, 32'hFFFF_FFFF, 0, 0};
      tbl[7] = '{0, 32'hFFFF_FFFC, 32'hA000_0004, 0, 32'h0,        0, 5};
      tbl[8] = '{0, 32'h0,        32'hA000_0005, 0, 32'h0,         1, 0};
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 0);
      chk("rst_inst", inst, 0);
      chk("rst_inst_valid", 32'(inst_valid), 0);
      chk("rst_req", 32'(imem_req), 0);
      chk("rst_addr", imem_addr, 0);
      chk("rst_running", 32'(running), 0);
`ifdef FETCH_SEQ_PERF_EN
      chk("rst_cycles", cycle_count, 0);
      chk("rst_retired", retired_count, 0);
`endif
      reset = 0;
      @(negedge clk);
      chk("idle_no_start", 32'(running), 0);
      for (int i = 0; i < 9; i++) begin
         if (tbl[i].rst) restart();
         run_instr(tbl[i]);
         if (tbl[i].hlt) begin
            chk("halt_running", 32'(running), 0);
            chk("halt_pc", pc, tbl[i].addr);
`ifdef FETCH_SEQ_PERF_EN
            if (i == 3) begin
               chk("cycle_count", cycle_count, 12);
               chk("retired_count", retired_count, 4);
            end
`endif
         end
      end
      start      = 1;
      imem_valid = 1;
      repeat (3) @(negedge clk);
      start      = 0;
      imem_valid = 0;
      chk("halt_sticky_running", 32'(running), 0);
      chk("halt_sticky_req", 32'(imem_req), 0);
      chk("halt_sticky_inst", inst, 32'hA000_0005);
      restart();
      @(negedge clk);
      imem_valid = 1;
      imem_data  = 32'h5555_AAAA;
      @(negedge clk);
      imem_valid = 0;
      chk("pre_rst_inst", inst, 32'h5555_AAAA);
      exec_ready    = 1;
      branch_taken  = 1;
      branch_target = 32'h100;
      reset         = 1;
      start         = 1;
      @(negedge clk);
      reset        = 0;
      start        = 0;
      exec_ready   = 0;
      branch_taken = 0;
      chk("rst_vs_accept_pc", pc, 0);
      chk("rst_vs_accept_running", 32'(running), 0);
      chk("rst_vs_accept_inst", inst, 0);
      start = 1;
      @(negedge clk);
      start = 0;
      chk("restart_req", 32'(imem_req), 1);
      chk("restart_addr", imem_addr, 0);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset      = 0;
      imem_valid = 1;
      imem_data  = 32'h7777_7777;
      @(negedge clk);
      imem_valid = 0;
      chk("late_valid_inst_valid", 32'(inst_valid), 0);
      chk("late_valid_inst", inst, 0);
      chk("late_valid_running", 32'(running), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
